// File: rtl/bcrypt_proxy_link_pkg.sv
// Shared definitions for the bcrypt proxy link: control codes carried on the
// shared ctrl bus, the TX/RX state encodings and fixed RX timing.
package bcrypt_proxy_link_pkg;

  // Control code driven alongside din to every proxy.
  typedef enum logic [1:0] {
    CtrlNone      = 2'd0,
    CtrlDataStart = 2'd1,
    CtrlInitStart = 2'd2,
    CtrlEnd       = 2'd3
  } ctrl_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxHdr,
    TxData,
    TxHold
  } tx_state_e;

  typedef enum logic [2:0] {
    RxPoll,
    RxReq,
    RxWait,
    RxShift,
    RxGap
  } rx_state_e;

  // Idle cycles after each result read; covers the proxy's read-tail delay.
  localparam int unsigned RxGapCycles = 10;

endpackage

// File: rtl/bcrypt_proxy_link_rx.sv
// Result path of the bcrypt proxy link. Polls proxy empty flags round-robin,
// issues a one-cycle rd_en, waits out the proxy's output latency and shifts
// the serial dout stream into a result word (first bit ends up in the MSB).
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   empty_i        per-proxy "no result" flags
//   dout_i         per-proxy serial result bit
//   rd_en_o        per-proxy read request (one-cycle pulse)
//   res_data_o     assembled result word
//   res_proxy_o    index of the proxy that produced res_data_o
//   res_valid_o    res_data_o/res_proxy_o valid, held until res_rd_i
//   res_rd_i       consume the held result
module bcrypt_proxy_link_rx
  import bcrypt_proxy_link_pkg::*;
#(
  parameter int unsigned NumProxies = 2,
  parameter int unsigned OutBits    = 32,
  parameter int unsigned OutLatency = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumProxies-1:0] empty_i,
  input  logic [NumProxies-1:0] dout_i,
  output logic [NumProxies-1:0] rd_en_o,
  output logic [OutBits-1:0]    res_data_o,
  output logic [3:0]            res_proxy_o,
  output logic                  res_valid_o,
  input  logic                  res_rd_i
);

  localparam int unsigned IdxW = (NumProxies > 1) ? $clog2(NumProxies) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumProxies - 1);

  rx_state_e          state_q;
  logic [IdxW-1:0]    idx_q;
  logic [IdxW-1:0]    idx_next;
  logic [15:0]        cnt_q;
  logic [OutBits-1:0] data_q;
  logic [3:0]         proxy_q;
  logic               valid_q;

  assign idx_next = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RxPoll;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      proxy_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && res_rd_i) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        // A held result freezes the scan so no read can complete on top of it.
        RxPoll: begin
          if (!valid_q) begin
            if (!empty_i[idx_q]) begin
              state_q <= RxReq;
            end else begin
              idx_q <= idx_next;
            end
          end
        end
        RxReq: begin
          cnt_q   <= 16'(OutLatency);
          state_q <= RxWait;
        end
        RxWait: begin
          if (cnt_q <= 16'd1) begin
            cnt_q   <= '0;
            state_q <= RxShift;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        // cnt_q counts received bits here; the word shifts in MSB-first.
        RxShift: begin
          data_q <= {data_q[OutBits-2:0], dout_i[idx_q]};
          if (cnt_q == 16'(OutBits - 1)) begin
            valid_q <= 1'b1;
            proxy_q <= 4'(idx_q);
            idx_q   <= idx_next;
            cnt_q   <= 16'(RxGapCycles - 1);
            state_q <= RxGap;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RxGap: begin
          if (cnt_q == '0) begin
            state_q <= RxPoll;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= RxPoll;
      endcase
    end
  end

  assign rd_en_o     = (state_q == RxReq) ? (NumProxies'(1) << idx_q) : '0;
  assign res_data_o  = data_q;
  assign res_proxy_o = proxy_q;
  assign res_valid_o = valid_q;

endmodule

// File: rtl/bcrypt_proxy_link.sv
// Arbiter-side peer of the bcrypt proxy interface.
// TX: pulls whole packets from a first-word-fall-through byte source, picks the
// target proxy set (all init-ready proxies for init packets, round-robin over
// crypt-ready proxies for data packets) and drives the shared din/ctrl bus with
// a one-cycle per-proxy wr_en header. RX lives in bcrypt_proxy_link_rx.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   src_*_i / src_rd_o  FWFT byte source (data, init flag, last flag, empty) and pop
//   din_o, ctrl_o       shared byte bus and control code to all proxies
//   wr_en_o             per-proxy packet start strobe
//   init_ready_i        per-proxy "can accept init packet"
//   crypt_ready_i       per-proxy "can accept data packet"
//   rd_en_o, empty_i,
//   dout_i              proxy result read interface
//   res_*               result word, source proxy index, valid, consume
//   err_underrun_o      sticky: source ran dry in the middle of a packet
module bcrypt_proxy_link
  import bcrypt_proxy_link_pkg::*;
#(
  parameter int unsigned NumProxies   = 2,
  parameter int unsigned OutBits      = 32,
  parameter int unsigned OutLatency   = 3,
  parameter int unsigned ReadyHoldoff = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            src_data_i,
  input  logic                  src_init_i,
  input  logic                  src_last_i,
  input  logic                  src_empty_i,
  output logic                  src_rd_o,
  output logic [7:0]            din_o,
  output logic [1:0]            ctrl_o,
  output logic [NumProxies-1:0] wr_en_o,
  input  logic [NumProxies-1:0] init_ready_i,
  input  logic [NumProxies-1:0] crypt_ready_i,
  output logic [NumProxies-1:0] rd_en_o,
  input  logic [NumProxies-1:0] empty_i,
  input  logic [NumProxies-1:0] dout_i,
  output logic [OutBits-1:0]    res_data_o,
  output logic [3:0]            res_proxy_o,
  output logic                  res_valid_o,
  input  logic                  res_rd_i,
  output logic                  err_underrun_o
);

  localparam int unsigned IdxW = (NumProxies > 1) ? $clog2(NumProxies) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumProxies - 1);

  tx_state_e             tx_state_q;
  logic [NumProxies-1:0] target_q;
  logic [IdxW-1:0]       tgt_idx_q;
  logic                  init_q;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [15:0]           hold_cnt_q;
  logic                  err_q;

  logic                  rr_found;
  logic [IdxW-1:0]       rr_idx;
  logic [IdxW-1:0]       cand;

  // First crypt-ready proxy at or after rr_ptr_q, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr_q;
    cand     = rr_ptr_q;
    for (int unsigned i = 0; i < NumProxies; i++) begin
      if (!rr_found && crypt_ready_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
      cand = (cand == LastIdx) ? '0 : cand + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= TxIdle;
      target_q   <= '0;
      tgt_idx_q  <= '0;
      init_q     <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (tx_state_q)
        TxIdle: begin
          if (!src_empty_i) begin
            if (src_init_i) begin
              if (|init_ready_i) begin
                target_q   <= init_ready_i;
                init_q     <= 1'b1;
                tx_state_q <= TxHdr;
              end
            end else if (rr_found) begin
              target_q   <= NumProxies'(1) << rr_idx;
              tgt_idx_q  <= rr_idx;
              init_q     <= 1'b0;
              tx_state_q <= TxHdr;
            end
          end
        end
        TxHdr: begin
          if (!init_q) begin
            rr_ptr_q <= (tgt_idx_q == LastIdx) ? '0 : tgt_idx_q + IdxW'(1);
          end
          tx_state_q <= TxData;
        end
        // An empty source mid-packet emits a zero filler byte and flags it.
        TxData: begin
          if (src_empty_i) begin
            err_q <= 1'b1;
          end else if (src_last_i) begin
            hold_cnt_q <= 16'(ReadyHoldoff - 1);
            tx_state_q <= TxHold;
          end
        end
        // Proxies need a few cycles after CtrlEnd before their ready flags drop.
        TxHold: begin
          if (hold_cnt_q == '0) begin
            tx_state_q <= TxIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q - 16'd1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  // Bytes pass straight from the FWFT head so the stream has no gaps.
  always_comb begin
    wr_en_o  = '0;
    ctrl_o   = CtrlNone;
    din_o    = '0;
    src_rd_o = 1'b0;
    case (tx_state_q)
      TxHdr: begin
        wr_en_o = target_q;
        ctrl_o  = init_q ? CtrlInitStart : CtrlDataStart;
      end
      TxData: begin
        if (!src_empty_i) begin
          din_o    = src_data_i;
          src_rd_o = 1'b1;
          ctrl_o   = src_last_i ? CtrlEnd : CtrlNone;
        end
      end
      default: ;
    endcase
  end

  assign err_underrun_o = err_q;

  bcrypt_proxy_link_rx #(
    .NumProxies (NumProxies),
    .OutBits    (OutBits),
    .OutLatency (OutLatency)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .empty_i     (empty_i),
    .dout_i      (dout_i),
    .rd_en_o     (rd_en_o),
    .res_data_o  (res_data_o),
    .res_proxy_o (res_proxy_o),
    .res_valid_o (res_valid_o),
    .res_rd_i    (res_rd_i)
  );

endmodule
